sm_alu_seq: RTL

Sequenced sign-magnitude ALU, the registered and parametrised successor to the combinational sign-magnitude operator set. It executes one operation per accepted request, selected by opcode: subtract, add, signed less-than, bit-clear, sign-magnitude→U2 conversion and an optional multi-cycle shift-add multiply. Results and the 4-bit status word are registered and qualified by a valid/ready handshake. It sits between the operand register file and the result write-back stage.

---
 rtl/sm_alu_seq_if.sv | 37 +++
 rtl/sm_alu_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_alu_seq_if.sv
// sm_alu_seq_if -- request/response bundle for the sequenced sign-magnitude ALU.
//
// Signals (directions as seen by the ALU, i.e. the slave side):
//   i_valid  in   request present
//   o_ready  out  ALU can accept a request this cycle
//   i_op     in   3-bit opcode
//   i_argA   in   operand A, sign-magnitude, M bits
//   i_argB   in   operand B, sign-magnitude / bit index, M bits
//   o_valid  out  one-cycle pulse: o_result/o_status are new
//   o_result out  result, M bits, held until the next result
//   o_status out  4-bit status word, held with o_result
//
// Modports: slave (the ALU), master (the requesting stage).
interface sm_alu_seq_if #(
  parameter int M = 8
) ();

  logic         i_valid;
  logic         o_ready;
  logic [2:0]   i_op;
  logic [M-1:0] i_argA;
  logic [M-1:0] i_argB;
  logic         o_valid;
  logic [M-1:0] o_result;
  logic [3:0]   o_status;

  modport slave (
    input  i_valid, i_op, i_argA, i_argB,
    output o_ready, o_valid, o_result, o_status
  );

  modport master (
    output i_valid, i_op, i_argA, i_argB,
    input  o_ready, o_valid, o_result, o_status
  );

endinterface

// File: rtl/sm_alu_seq.sv
// sm_alu_seq -- sequenced sign-magnitude ALU.
//
// Executes one operation per accepted request: SUB, LT, CLRBIT, SM2U2, ADD and
// (optionally) a multi-cycle shift-add MUL. Result and status are registered
// and announced with a one-cycle o_valid pulse.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      sm_alu_seq_if.slave: i_valid/o_ready request handshake,
//            i_op/i_argA/i_argB operands, o_valid/o_result/o_status result
//
// Parameter M: operand/result width (MSB sign, M-1 magnitude bits), M >= 3.
//
// Build option: define SM_ALU_MUL_EN to build the MUL state, counter and
// accumulator. Without it, opcode 101 is handled like an illegal opcode.
//
// Status word: [0] error, [1] result MSB, [2] even number of ones in the
// result, [3] result all ones. Bits [3:1] are always derived from the emitted
// result, so an error (result forced to 0) always reads 4'b0101.
module sm_alu_seq #(
  parameter int M = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sm_alu_seq_if.slave bus
);

  localparam logic [2:0]   OP_SUB    = 3'b000;
  localparam logic [2:0]   OP_LT     = 3'b001;
  localparam logic [2:0]   OP_CLRBIT = 3'b010;
  localparam logic [2:0]   OP_SM2U2  = 3'b011;
  localparam logic [2:0]   OP_ADD    = 3'b100;
`ifdef SM_ALU_MUL_EN
  localparam logic [2:0]   OP_MUL    = 3'b101;
  localparam int           CW        = $clog2(M);
  localparam logic [CW-1:0] MUL_LAST = CW'(M - 2);
  localparam int           PW        = 2 * M - 2;
`endif
  localparam logic [M-1:0] ONE       = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M-1:0] BIT_LIMIT = M'(M);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
`ifdef SM_ALU_MUL_EN
    ST_MUL  = 2'b01,
`endif
    ST_DONE = 2'b10
  } state_t;

  // Status word derived from the emitted result; bit 2 is even parity.
  function automatic logic [3:0] status_f(input logic [M-1:0] r, input logic err);
    status_f = {&r, ~^r, r[M-1], err};
  endfunction

  // Pack sign and magnitude, forcing a zero magnitude to +0.
  function automatic logic [M-1:0] pack_sm_f(input logic s, input logic [M-2:0] mag);
    pack_sm_f = {s & (|mag), mag};
  endfunction

  state_t       state_r;
  state_t       state_nx_s;
  logic         o_valid_r;
  logic [M-1:0] result_r;
  logic [3:0]   status_r;
  logic         ready_s;
  logic         accept_s;
  logic         accept_sc_s;

  // Operand fields and shared arithmetic for the single-cycle ops.
  logic         sa_s;
  logic         sb_s;
  logic         sb_eff_s;
  logic [M-2:0] ma_s;
  logic [M-2:0] mb_s;
  logic [M-1:0] sum_s;
  logic [M-2:0] diff_ab_s;
  logic [M-2:0] diff_ba_s;
  logic [M-1:0] cleared_s;
  logic         a_neg_s;
  logic         b_neg_s;
  logic         lt_s;
  logic [M-1:0] sc_result_s;
  logic         sc_err_s;

  assign sa_s      = bus.i_argA[M-1];
  assign sb_s      = bus.i_argB[M-1];
  assign ma_s      = bus.i_argA[M-2:0];
  assign mb_s      = bus.i_argB[M-2:0];
  // SUB is ADD with the sign of B flipped.
  assign sb_eff_s  = sb_s ^ (bus.i_op == OP_SUB);
  assign sum_s     = {1'b0, ma_s} + {1'b0, mb_s};
  assign diff_ab_s = ma_s - mb_s;
  assign diff_ba_s = mb_s - ma_s;
  assign cleared_s = bus.i_argA & ~(ONE << bus.i_argB);
  // -0 is not negative for the compare.
  assign a_neg_s   = sa_s & (|ma_s);
  assign b_neg_s   = sb_s & (|mb_s);

`ifdef SM_ALU_MUL_EN
  assign ready_s   = (state_r != ST_MUL);
`else
  assign ready_s   = 1'b1;
`endif
  assign accept_s  = bus.i_valid && ready_s;

  // Signed less-than on sign-magnitude operands.
  always_comb begin
    lt_s = 1'b0;
    if (a_neg_s != b_neg_s) begin
      lt_s = a_neg_s;
    end else if (a_neg_s) begin
      lt_s = (ma_s > mb_s);
    end else begin
      lt_s = (ma_s < mb_s);
    end
  end

  // Result and error of every op that completes at the accept edge.
  always_comb begin
    sc_result_s = '0;
    sc_err_s    = 1'b0;
    case (bus.i_op)
      OP_SUB, OP_ADD: begin
        if (sa_s == sb_eff_s) begin
          if (sum_s[M-1]) begin
            sc_err_s = 1'b1;
          end else begin
            sc_result_s = pack_sm_f(sa_s, sum_s[M-2:0]);
          end
        end else if (ma_s >= mb_s) begin
          sc_result_s = pack_sm_f(sa_s, diff_ab_s);
        end else begin
          sc_result_s = pack_sm_f(sb_eff_s, diff_ba_s);
        end
      end
      OP_LT: begin
        sc_result_s = {{(M-1){1'b0}}, lt_s};
      end
      OP_CLRBIT: begin
        if (sb_s || (bus.i_argB >= BIT_LIMIT)) begin
          sc_err_s = 1'b1;
        end else begin
          sc_result_s = pack_sm_f(cleared_s[M-1], cleared_s[M-2:0]);
        end
      end
      OP_SM2U2: begin
        if (!sa_s) begin
          sc_result_s = bus.i_argA;
        end else if (ma_s == '0) begin
          sc_err_s = 1'b1;
        end else begin
          sc_result_s = ~{1'b0, ma_s} + ONE;
        end
      end
`ifdef SM_ALU_MUL_EN
      OP_MUL: begin
        // Produced later by the multiplier path.
        sc_result_s = '0;
        sc_err_s    = 1'b0;
      end
`endif
      default: begin
        sc_err_s = 1'b1;
      end
    endcase
  end

`ifdef SM_ALU_MUL_EN
  logic [CW-1:0] cnt_r;
  logic [PW-1:0] acc_r;
  logic [PW-1:0] mcand_r;
  logic [M-2:0]  mplier_r;
  logic          msign_r;
  logic          accept_mul_s;
  logic          mul_last_s;
  logic [PW-1:0] acc_nx_s;
  logic          mul_err_s;
  logic [M-1:0]  mul_result_s;

  assign accept_mul_s = accept_s && (bus.i_op == OP_MUL);
  assign accept_sc_s  = accept_s && (bus.i_op != OP_MUL);

  // One shift-add step and the final product check.
  always_comb begin
    acc_nx_s     = acc_r;
    mul_err_s    = 1'b0;
    mul_result_s = '0;
    if (mplier_r[0]) begin
      acc_nx_s = acc_r + mcand_r;
    end else begin
      acc_nx_s = acc_r;
    end
    if (|acc_nx_s[PW-1:M-1]) begin
      mul_err_s = 1'b1;
    end else begin
      mul_result_s = pack_sm_f(msign_r, acc_nx_s[M-2:0]);
    end
  end
`else
  assign accept_sc_s  = accept_s;
`endif

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
`ifdef SM_ALU_MUL_EN
    mul_last_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
`ifdef SM_ALU_MUL_EN
          if (bus.i_op == OP_MUL) begin
            state_nx_s = ST_MUL;
          end else begin
            state_nx_s = ST_DONE;
          end
`else
          state_nx_s = ST_DONE;
`endif
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
`ifdef SM_ALU_MUL_EN
      ST_MUL: begin
        if (cnt_r == MUL_LAST) begin
          state_nx_s = ST_DONE;
          mul_last_s = 1'b1;
        end else begin
          state_nx_s = ST_MUL;
        end
      end
`endif
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register and result-valid pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      o_valid_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      o_valid_r <= (state_nx_s == ST_DONE);
    end
  end

  // Result/status registers: written at a single-cycle accept or at the last
  // multiply step, otherwise held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result_r <= '0;
      status_r <= 4'b0000;
    end else if (accept_sc_s) begin
      result_r <= sc_result_s;
      status_r <= status_f(sc_result_s, sc_err_s);
`ifdef SM_ALU_MUL_EN
    end else if (mul_last_s) begin
      result_r <= mul_result_s;
      status_r <= status_f(mul_result_s, mul_err_s);
`endif
    end else begin
      result_r <= result_r;
      status_r <= status_r;
    end
  end

`ifdef SM_ALU_MUL_EN
  // Multiplier datapath: load at accept, one multiplier bit per MUL cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r    <= '0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      msign_r  <= 1'b0;
    end else if (accept_mul_s) begin
      cnt_r    <= '0;
      acc_r    <= '0;
      mcand_r  <= {{(M-1){1'b0}}, ma_s};
      mplier_r <= mb_s;
      msign_r  <= sa_s ^ sb_s;
    end else if (state_r == ST_MUL) begin
      cnt_r    <= mul_last_s ? '0 : cnt_r + CW'(1);
      acc_r    <= acc_nx_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      msign_r  <= msign_r;
    end else begin
      cnt_r    <= cnt_r;
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      msign_r  <= msign_r;
    end
  end
`endif

  assign bus.o_ready  = ready_s;
  assign bus.o_valid  = o_valid_r;
  assign bus.o_result = result_r;
  assign bus.o_status = status_r;

endmodule
